// File: rtl/icache_line_fill_if.sv
// Pipelined Wishbone read channel between the line-fill master and the
// instruction-side memory port.
interface icache_line_fill_if #(
    parameter int AW = 32,
    parameter int MW = 64
);
    logic          cyc;
    logic          stb;
    logic [AW-1:0] addr;
    logic          stall;
    logic          ack;
    logic          err;
    logic [MW-1:0] data;

    modport master (output cyc, stb, addr, input  stall, ack, err, data);
    modport slave  (input  cyc, stb, addr, output stall, ack, err, data);
endinterface

// File: rtl/icache_line_fill.sv
// L1i line refill: issues LINE_BEATS pipelined Wishbone reads for one aligned
// line and streams the acknowledged beats, in order, into the data array.
module icache_line_fill #(
    parameter  int AW         = 32,
    parameter  int MW         = 64,
    parameter  int LINE_BEATS = 4,
    localparam int BW         = MW / 8,
    localparam int LINE_BYTES = LINE_BEATS * BW,
    localparam int IW         = $clog2(LINE_BEATS)
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_req,
    input  logic [AW-1:0]          i_req_addr,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_err,
    output logic                   o_fill_we,
    output logic [IW-1:0]          o_fill_idx,
    output logic [MW-1:0]          o_fill_data,
    icache_line_fill_if.master     wb
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

    localparam logic [AW-1:0] OFF_MASK = AW'(LINE_BYTES - 1);
    localparam logic [IW:0]   CNT_LAST = (IW+1)'(LINE_BEATS - 1);
    localparam logic [IW:0]   CNT_FULL = (IW+1)'(LINE_BEATS);

    // Every output lives in this register bundle, so nothing on the bus side
    // is combinationally derived from a bus input.
    typedef struct packed {
        state_t        state;
        logic          busy;
        logic          done;
        logic          err;
        logic          fill_we;
        logic [IW-1:0] fill_idx;
        logic [MW-1:0] fill_data;
        logic          cyc;
        logic          stb;
        logic [AW-1:0] addr;
        logic [IW:0]   issued;
        logic [IW:0]   acked;
    } regs_t;

    regs_t r, rn;

    logic          accept;
    logic          ack_ok;
    logic          bus_err;
    logic [AW-1:0] line_base;
    logic [AW-1:0] next_addr;

    assign accept    = r.stb && !wb.stall;
    assign ack_ok    = r.cyc && wb.ack && !wb.err && (r.acked < CNT_FULL);
    assign bus_err   = r.cyc && wb.err;
    assign line_base = i_req_addr & ~OFF_MASK;
    // Offset wraps inside the line so the held address never leaves it.
    assign next_addr = (r.addr & ~OFF_MASK) | ((r.addr + AW'(BW)) & OFF_MASK);

    always_ff @(posedge i_clk) begin
        if (i_reset) r <= '0;
        else         r <= rn;
    end

    always_comb begin
        rn         = r;
        rn.done    = 1'b0;
        rn.err     = 1'b0;
        rn.fill_we = 1'b0;

        case (r.state)
            IDLE: begin
                if (i_req) begin
                    rn.state  = ISSUE;
                    rn.addr   = line_base;
                    rn.cyc    = 1'b1;
                    rn.stb    = 1'b1;
                    rn.issued = '0;
                    rn.acked  = '0;
                end
            end
            ISSUE, DRAIN: begin
                if (accept) begin
                    rn.issued = r.issued + 1'b1;
                    rn.addr   = next_addr;
                    if (r.issued == CNT_LAST) begin
                        rn.stb   = 1'b0;
                        rn.state = DRAIN;
                    end
                end
                if (ack_ok) begin
                    rn.fill_we   = 1'b1;
                    rn.fill_idx  = r.acked[IW-1:0];
                    rn.fill_data = wb.data;
                    rn.acked     = r.acked + 1'b1;
                    if (r.acked == CNT_LAST) begin
                        rn.cyc   = 1'b0;
                        rn.stb   = 1'b0;
                        rn.done  = 1'b1;
                        rn.state = FINISH;
                    end
                end
            end
            FINISH:  rn.state = IDLE;
            default: rn.state = IDLE;
        endcase

        // A bus error abandons the line; it outranks any ack in the same cycle.
        if (bus_err) begin
            rn.state   = IDLE;
            rn.cyc     = 1'b0;
            rn.stb     = 1'b0;
            rn.err     = 1'b1;
            rn.done    = 1'b0;
            rn.fill_we = 1'b0;
        end

        rn.busy = (rn.state != IDLE);
    end

    assign o_busy      = r.busy;
    assign o_done      = r.done;
    assign o_err       = r.err;
    assign o_fill_we   = r.fill_we;
    assign o_fill_idx  = r.fill_idx;
    assign o_fill_data = r.fill_data;
    assign wb.cyc      = r.cyc;
    assign wb.stb      = r.stb;
    assign wb.addr     = r.addr;

endmodule

// File: tb/tb_icache_line_fill.sv
// Directed bench for icache_line_fill: a pipelined slave model answers each
// accepted beat one cycle later; a monitor scores fill writes against a queue.
module tb_icache_line_fill;
    localparam int AW = 32;
    localparam int MW = 64;
    localparam int LB = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic          busy, done, err, fill_we;
    logic [IW-1:0] fill_idx;
    logic [MW-1:0] fill_data;

    icache_line_fill_if #(.AW(AW), .MW(MW)) wb ();

    icache_line_fill #(.AW(AW), .MW(MW), .LINE_BEATS(LB)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_req       (req),
        .i_req_addr  (req_addr),
        .o_busy      (busy),
        .o_done      (done),
        .o_err       (err),
        .o_fill_we   (fill_we),
        .o_fill_idx  (fill_idx),
        .o_fill_data (fill_data),
        .wb          (wb.master)
    );

    always #5 clk = ~clk;

    int cnt = 0;
    always @(posedge clk) cnt <= cnt + 1;

    typedef struct {
        logic [IW-1:0] idx;
        logic [MW-1:0] data;
    } fill_t;

    fill_t exp_q[$];
    fill_t mf;
    int    t0 = 0, tests = 0, fails = 0;
    int    st_lo = 1000, st_hi = -1, err_ack = -1, ack_n = 0;
    bit    err_keep = 1'b0, spur = 1'b0;
    int    done_cnt = 0, err_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cnt - t0);
        end
    endtask

    task automatic push(input int idx, input logic [AW-1:0] a);
        fill_t f;
        f.idx  = IW'(idx);
        f.data = {32'hCAFE_0000, a};
        exp_q.push_back(f);
    endtask

    task automatic push_line(input logic [AW-1:0] base);
        for (int i = 0; i < LB; i++) push(i, base + AW'(8 * i));
    endtask

    task automatic start(input logic [AW-1:0] a);
        @(posedge clk);
        #1;
        t0       = cnt;
        ack_n    = 0;
        req      = 1'b1;
        req_addr = a;
    endtask

    // Park at the falling edge of relative cycle n.
    task automatic at(input int n);
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (cnt < t0 + n && g < 500);
        if (cnt != t0 + n) begin
            tests++;
            fails++;
            $display("FAIL wait_cycle: reached %0d, required %0d", cnt - t0, n);
        end
    endtask

    task automatic gap();
        repeat (3) @(negedge clk);
    endtask

    // Slave: stall window by relative cycle, ack one cycle after acceptance.
    initial begin
        bit            acc;
        logic [AW-1:0] acc_addr;
        int            rel;
        wb.stall = 1'b0;
        wb.ack   = 1'b0;
        wb.err   = 1'b0;
        wb.data  = '0;
        forever begin
            @(negedge clk);
            acc      = wb.cyc && wb.stb && !wb.stall;
            acc_addr = wb.addr;
            @(posedge clk);
            #2;
            rel      = cnt - t0;
            wb.stall = (rel >= st_lo && rel <= st_hi);
            wb.ack   = 1'b0;
            wb.err   = 1'b0;
            if (acc) begin
                if (ack_n == err_ack) begin
                    wb.err = 1'b1;
                    wb.ack = err_keep;
                end else begin
                    wb.ack = 1'b1;
                end
                wb.data = {32'hCAFE_0000, acc_addr};
                ack_n++;
            end
            if (spur) begin
                wb.ack  = 1'b1;
                wb.data = '1;
            end
        end
    end

    // Monitor: every fill write must match the head of the expectation queue.
    initial begin
        forever begin
            @(negedge clk);
            if (fill_we) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_fill: idx %0d data %h, required no write", fill_idx, fill_data);
                end else begin
                    mf = exp_q.pop_front();
                    chk("fill_idx", 64'(fill_idx), 64'(mf.idx));
                    chk("fill_data", fill_data, mf.data);
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_with_we", 64'(fill_we), 64'd1);
            end
            if (err) err_cnt++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_err", 64'(err), 0);
        chk("rst_we", 64'(fill_we), 0);
        chk("rst_cyc", 64'(wb.cyc), 0);
        chk("rst_stb", 64'(wb.stb), 0);
        chk("rst_addr", 64'(wb.addr), 0);
        chk("rst_idx", 64'(fill_idx), 0);
        chk("rst_data", fill_data, 0);
        rst = 1'b0;
        gap();

        // no-stall refill
        push_line(32'h1220);
        start(32'h1234);
        at(0); chk("t1_idle_busy", 64'(busy), 0);
        at(1); req = 1'b0;
               chk("t1_addr1", 64'(wb.addr), 64'h1220);
               chk("t1_stb1", 64'(wb.stb), 1);
               chk("t1_busy1", 64'(busy), 1);
        at(2); chk("t1_addr2", 64'(wb.addr), 64'h1228);
        at(3); chk("t1_addr3", 64'(wb.addr), 64'h1230);
        at(4); chk("t1_addr4", 64'(wb.addr), 64'h1238);
        at(5); chk("t1_stb5", 64'(wb.stb), 0);
               chk("t1_cyc5", 64'(wb.cyc), 1);
        at(6); chk("t1_done6", 64'(done), 1);
               chk("t1_cyc6", 64'(wb.cyc), 0);
               chk("t1_busy6", 64'(busy), 1);
        at(7); chk("t1_done7", 64'(done), 0);
               chk("t1_busy7", 64'(busy), 0);
        gap();

        // stall in cycles 1-2
        push_line(32'h1220);
        st_lo = 1; st_hi = 2;
        start(32'h1234);
        at(1); req = 1'b0;
        at(2); chk("t2_addr2", 64'(wb.addr), 64'h1220);
        at(3); chk("t2_addr3", 64'(wb.addr), 64'h1220);
        at(4); chk("t2_addr4", 64'(wb.addr), 64'h1228);
        at(6); chk("t2_stb6", 64'(wb.stb), 1);
        at(7); chk("t2_stb7", 64'(wb.stb), 0);
        at(8); chk("t2_done8", 64'(done), 1);
        at(9); chk("t2_done9", 64'(done), 0);
        st_lo = 1000; st_hi = -1;
        gap();

        // error in place of the second ack
        push(0, 32'h1220);
        err_ack = 1; err_keep = 1'b0;
        start(32'h1234);
        at(1); req = 1'b0;
        at(3); chk("t3_we3", 64'(fill_we), 1);
        at(4); chk("t3_err4", 64'(err), 1);
               chk("t3_cyc4", 64'(wb.cyc), 0);
               chk("t3_stb4", 64'(wb.stb), 0);
               chk("t3_busy4", 64'(busy), 0);
               chk("t3_done4", 64'(done), 0);
        at(5); chk("t3_err5", 64'(err), 0);
               chk("t3_we5", 64'(fill_we), 0);
        err_ack = -1;
        gap();

        // reset in cycle 3, then a clean refill
        push(0, 32'h1220);
        start(32'h1234);
        at(1); req = 1'b0;
        at(3); rst = 1'b1;
        at(4); chk("t4_busy", 64'(busy), 0);
               chk("t4_cyc", 64'(wb.cyc), 0);
               chk("t4_stb", 64'(wb.stb), 0);
               chk("t4_we", 64'(fill_we), 0);
               chk("t4_addr", 64'(wb.addr), 0);
               chk("t4_idx", 64'(fill_idx), 0);
               chk("t4_data", fill_data, 0);
               chk("t4_done", 64'(done), 0);
               chk("t4_err", 64'(err), 0);
               rst = 1'b0;
        at(5); chk("t4_late_we", 64'(fill_we), 0);
        gap();
        push_line(32'hABC0);
        start(32'h0000_ABCF);
        at(1); req = 1'b0;
               chk("t4b_addr1", 64'(wb.addr), 64'hABC0);
        at(4); chk("t4b_addr4", 64'(wb.addr), 64'hABD8);
        at(6); chk("t4b_done6", 64'(done), 1);
        gap();

        // i_req held high; address wiggle mid-refill is ignored
        push_line(32'h2000);
        push_line(32'h2000);
        start(32'h2008);
        at(2); req_addr = 32'h9000;
        at(3); chk("t5_addr3", 64'(wb.addr), 64'h2010);
               req_addr = 32'h2008;
        at(6); chk("t5_done6", 64'(done), 1);
        at(7); chk("t5_stb7", 64'(wb.stb), 0);
               chk("t5_busy7", 64'(busy), 0);
        at(8); chk("t5_stb8", 64'(wb.stb), 1);
               chk("t5_addr8", 64'(wb.addr), 64'h2000);
               req = 1'b0;
        at(13); chk("t5_done13", 64'(done), 1);
        gap();

        // spurious ack while idle
        t0 = cnt;
        spur = 1'b1;
        at(1); spur = 1'b0;
        at(2); chk("spur_we", 64'(fill_we), 0);
        gap();

        // ack and err together on the third beat
        push(0, 32'h1220);
        push(1, 32'h1228);
        err_ack = 2; err_keep = 1'b1;
        start(32'h1234);
        at(1); req = 1'b0;
        at(4); chk("t6_we4", 64'(fill_we), 1);
        at(5); chk("t6_err5", 64'(err), 1);
               chk("t6_we5", 64'(fill_we), 0);
               chk("t6_cyc5", 64'(wb.cyc), 0);
        at(6); chk("t6_we6", 64'(fill_we), 0);
        err_ack = -1;
        gap();

        chk("sb_empty", 64'(exp_q.size()), 0);
        chk("done_count", 64'(done_cnt), 5);
        chk("err_count", 64'(err_cnt), 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
